// File: rtl/fpdiv_ctrl_pkg.sv
// fpdiv_ctrl_pkg: shared types and constants for the Goldschmidt divider
// sequencer.
//   state_t    - controller state encoding
//   SELA_* / SELB_* - datapath mux select codes
//   is_step()  - true for states that occupy a timed datapath step
package fpdiv_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT_D,
      INIT_N,
      ITER_N,
      ITER_D,
      DONE
   } state_t;

   // mux A: multiplier operand A
   localparam logic [1:0] SELA_REGA = 2'd0;
   localparam logic [1:0] SELA_D    = 2'd1;
   localparam logic [1:0] SELA_IA   = 2'd2;

   // mux B: multiplier operand B
   localparam logic [1:0] SELB_D    = 2'd0;
   localparam logic [1:0] SELB_X    = 2'd1;
   localparam logic [1:0] SELB_REGB = 2'd2;
   localparam logic [1:0] SELB_REGC = 2'd3;

   function automatic logic is_step(input state_t s);
      return (s == INIT_D) || (s == INIT_N) || (s == ITER_N) || (s == ITER_D);
   endfunction

endpackage

// File: rtl/fpdiv_step_timer.sv
// fpdiv_step_timer: sub-cycle down-counter measuring one datapath step.
//   clk, reset     - clock, synchronous active-high reset (count -> 0)
//   clear          - start a new step (count reloads to STEP_CYCLES-1)
//   step_last      - current clock is the final clock of the step
//   step_last_nxt  - next clock will be the final clock of the step; lets the
//                    parent register its load strobes one cycle ahead
module fpdiv_step_timer
   import fpdiv_ctrl_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic step_last,
   output logic step_last_nxt
);

   localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   // Counter saturates at zero so it rests there outside a step.
   always_comb begin
      cnt_nxt = cnt;
      if (clear)
         cnt_nxt = CW'(STEP_CYCLES - 1);
      else if (cnt != '0)
         cnt_nxt = cnt - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

   assign step_last     = (cnt == '0);
   assign step_last_nxt = (cnt_nxt == '0);

endmodule

// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: sequencing FSM for the 24-bit Goldschmidt divider datapath.
//   clk, reset      - clock, synchronous active-high reset
//   start, abort    - request / cancel a divide (start sampled only in IDLE)
//   busy, done      - operation in progress / one-cycle completion pulse
//   sel_muxa/b      - datapath multiplier operand selects
//   load_rega/b/c   - datapath register load strobes (pulsed on the last
//                     clock of each step)
// Every output is a flop computed from the next state, so the strobes used
// for clock gating change only just after the rising edge.
module fpdiv_ctrl
   import fpdiv_ctrl_pkg::*;
#(
   parameter int unsigned ITER        = 3,
   parameter int unsigned STEP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic [1:0] sel_muxa,
   output logic [1:0] sel_muxb,
   output logic       load_rega,
   output logic       load_regb,
   output logic       load_regc
);

   localparam logic [2:0] ITER_LAST = 3'(ITER - 1);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] iter_cnt;
   logic [2:0] iter_cnt_nxt;
   logic       step_last;
   logic       step_last_nxt;
   logic       timer_clear;

   logic       busy_nxt;
   logic       done_nxt;
   logic [1:0] sela_nxt;
   logic [1:0] selb_nxt;
   logic       lda_nxt;
   logic       ldb_nxt;
   logic       ldc_nxt;

   // Every step transition enters a different state, so a state change into
   // a step state marks the first clock of a new step.
   assign timer_clear = is_step(state_nxt) && (state_nxt != state);

   fpdiv_step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_step_timer (
      .clk          (clk),
      .reset        (reset),
      .clear        (timer_clear),
      .step_last    (step_last),
      .step_last_nxt(step_last_nxt)
   );

   // State register, including the registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         iter_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sel_muxa  <= SELA_REGA;
         sel_muxb  <= SELB_D;
         load_rega <= 1'b0;
         load_regb <= 1'b0;
         load_regc <= 1'b0;
      end else begin
         state     <= state_nxt;
         iter_cnt  <= iter_cnt_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         sel_muxa  <= sela_nxt;
         sel_muxb  <= selb_nxt;
         load_rega <= lda_nxt;
         load_regb <= ldb_nxt;
         load_regc <= ldc_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt    = state;
      iter_cnt_nxt = iter_cnt;
      if (abort) begin
         state_nxt    = IDLE;
         iter_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt    = INIT_D;
                  iter_cnt_nxt = '0;
               end
            end
            INIT_D: if (step_last) state_nxt = INIT_N;
            INIT_N: if (step_last) state_nxt = ITER_N;
            ITER_N: begin
               // the final iteration needs no new denominator / K
               if (step_last)
                  state_nxt = (iter_cnt < ITER_LAST) ? ITER_D : DONE;
            end
            ITER_D: begin
               if (step_last) begin
                  state_nxt    = ITER_N;
                  iter_cnt_nxt = iter_cnt + 3'd1;
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output logic: values the outputs take in the next cycle.
   always_comb begin
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE);
      sela_nxt = SELA_REGA;
      selb_nxt = SELB_D;
      lda_nxt  = 1'b0;
      ldb_nxt  = 1'b0;
      ldc_nxt  = 1'b0;
      case (state_nxt)
         INIT_D: begin
            sela_nxt = SELA_IA;
            selb_nxt = SELB_D;
            lda_nxt  = step_last_nxt;
            ldc_nxt  = step_last_nxt;
         end
         INIT_N: begin
            sela_nxt = SELA_IA;
            selb_nxt = SELB_X;
            ldb_nxt  = step_last_nxt;
         end
         ITER_N: begin
            sela_nxt = SELA_REGA;
            selb_nxt = SELB_REGB;
            ldb_nxt  = step_last_nxt;
         end
         ITER_D: begin
            sela_nxt = SELA_REGA;
            selb_nxt = SELB_REGC;
            lda_nxt  = step_last_nxt;
            ldc_nxt  = step_last_nxt;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: drives three controller configurations from shared
// start/abort/reset stimulus and compares every output every cycle against a
// position-in-operation reference model.
//   cfg0: ITER=3 STEP_CYCLES=1   cfg1: ITER=3 STEP_CYCLES=3
//   cfg2: ITER=1 STEP_CYCLES=1
module tb_fpdiv_ctrl;

   localparam int NCFG = 3;
   localparam int CFG_ITER [NCFG] = '{3, 3, 1};
   localparam int CFG_STEP [NCFG] = '{1, 3, 1};

   logic clk = 1'b0;
   logic reset_i;
   logic start_i;
   logic abort_i;

   logic       busy   [NCFG];
   logic       done   [NCFG];
   logic [1:0] sela   [NCFG];
   logic [1:0] selb   [NCFG];
   logic       lda    [NCFG];
   logic       ldb    [NCFG];
   logic       ldc    [NCFG];

   int pos [NCFG];        // 0 = idle, else clocks since the start was accepted
   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   always #5 clk = ~clk;

   fpdiv_ctrl #(.ITER(3), .STEP_CYCLES(1)) u_cfg0 (
      .clk(clk), .reset(reset_i), .start(start_i), .abort(abort_i),
      .busy(busy[0]), .done(done[0]), .sel_muxa(sela[0]), .sel_muxb(selb[0]),
      .load_rega(lda[0]), .load_regb(ldb[0]), .load_regc(ldc[0]));

   fpdiv_ctrl #(.ITER(3), .STEP_CYCLES(3)) u_cfg1 (
      .clk(clk), .reset(reset_i), .start(start_i), .abort(abort_i),
      .busy(busy[1]), .done(done[1]), .sel_muxa(sela[1]), .sel_muxb(selb[1]),
      .load_rega(lda[1]), .load_regb(ldb[1]), .load_regc(ldc[1]));

   fpdiv_ctrl #(.ITER(1), .STEP_CYCLES(1)) u_cfg2 (
      .clk(clk), .reset(reset_i), .start(start_i), .abort(abort_i),
      .busy(busy[2]), .done(done[2]), .sel_muxa(sela[2]), .sel_muxb(selb[2]),
      .load_rega(lda[2]), .load_regb(ldb[2]), .load_regc(ldc[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected {busy, done, sela, selb, load_a, load_b, load_c} at position p.
   // Steps: 0 = D0/K1, 1 = N0, then alternating N_i / D_i, 2*it+1 steps total.
   function automatic logic [8:0] model_out(input int it, input int sc, input int p);
      int total;
      int stp;
      logic last;
      logic [1:0] sa, sb;
      logic a, b, c;
      total = (2 * it + 1) * sc;
      if (p == 0) return 9'd0;
      if (p == total + 1) return 9'b1_1_00_00_000;
      stp  = (p - 1) / sc;
      last = (((p - 1) % sc) == sc - 1);
      if (stp == 0) begin
         sa = 2'd2; sb = 2'd0; a = 1'b1; b = 1'b0; c = 1'b1;
      end else if (stp == 1) begin
         sa = 2'd2; sb = 2'd1; a = 1'b0; b = 1'b1; c = 1'b0;
      end else if (((stp - 2) % 2) == 0) begin
         sa = 2'd0; sb = 2'd2; a = 1'b0; b = 1'b1; c = 1'b0;
      end else begin
         sa = 2'd0; sb = 2'd3; a = 1'b1; b = 1'b0; c = 1'b1;
      end
      return {1'b1, 1'b0, sa, sb, a & last, b & last, c & last};
   endfunction

   // One clock: apply inputs, advance the model at the edge, compare at negedge.
   task automatic tick(input logic r, input logic s, input logic a);
      reset_i = r;
      start_i = s;
      abort_i = a;
      @(posedge clk);
      for (int k = 0; k < NCFG; k++) begin
         if (r || a)
            pos[k] = 0;
         else if (pos[k] == 0)
            pos[k] = s ? 1 : 0;
         else if (pos[k] == (2 * CFG_ITER[k] + 1) * CFG_STEP[k] + 1)
            pos[k] = 0;
         else
            pos[k] = pos[k] + 1;
      end
      @(negedge clk);
      for (int k = 0; k < NCFG; k++) begin
         check($sformatf("cfg%0d_outputs", k),
               32'({busy[k], done[k], sela[k], selb[k], lda[k], ldb[k], ldc[k]}),
               32'(model_out(CFG_ITER[k], CFG_STEP[k], pos[k])));
      end
      if (done[0]) done_seen++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_i = 1'b1;
      start_i = 1'b0;
      abort_i = 1'b0;
      for (int k = 0; k < NCFG; k++) pos[k] = 0;

      // reset state
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);

      // plain operation
      tick(1'b0, 1'b1, 1'b0);
      idle(25);

      // abort at cycle 4, restart at cycle 6
      tick(1'b0, 1'b1, 1'b0);
      idle(3);
      tick(1'b0, 1'b0, 1'b1);
      idle(1);
      tick(1'b0, 1'b1, 1'b0);
      idle(25);

      // start pulses while busy are ignored
      done_seen = 0;
      tick(1'b0, 1'b1, 1'b0);
      idle(2);
      tick(1'b0, 1'b1, 1'b0);
      idle(1);
      tick(1'b0, 1'b1, 1'b0);
      idle(25);
      check("single_done", 32'(done_seen), 32'd1);

      // start and abort together in IDLE
      tick(1'b0, 1'b1, 1'b1);
      idle(3);

      // reset while cfg0 sits in its first ITER_D
      tick(1'b0, 1'b1, 1'b0);
      idle(3);
      tick(1'b1, 1'b0, 1'b0);
      idle(25);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 99) < 25),
              ($urandom_range(0, 99) < 3));
      end
      idle(25);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
